envelope_vca: RTL and testbench

- Per-voice ADSR envelope generator plus VCA, directly downstream of the oscillator stage.
- Consumes the oscillator's unsigned, midpoint-offset sample and produces an amplitude-scaled sample in the same format, ready for the voice mixer.
- A gate input drives the attack/decay/sustain/release state machine; one envelope step per sample_clock.

---
 rtl/envelope_vca.sv | 139 +++++++++++++
 tb/tb_envelope_vca.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/envelope_vca.sv
// Per-voice ADSR envelope generator with a two-stage VCA on the oscillator sample.
// Optional macro ENVELOPE_EXP_RELEASE_EN: level-proportional decay/release steps.
module envelope_vca #(
  parameter int BITDEPTH = 14,
  parameter int ACCBITS  = 16
) (
  input  logic                sample_clock,
  input  logic                reset,
  input  logic                gate,
  input  logic [7:0]          attack_rate,
  input  logic [7:0]          decay_rate,
  input  logic [7:0]          sustain_level,
  input  logic [7:0]          release_rate,
  input  logic [BITDEPTH-1:0] audio_in,
  output logic [BITDEPTH-1:0] audio_out,
  output logic [7:0]          envelope,
  output logic                active
);

  localparam logic [BITDEPTH-1:0] MIDPOINT = BITDEPTH'((1 << (BITDEPTH-1)) - 1);
  localparam logic [ACCBITS-1:0]  ACC_MAX  = '1;
  localparam logic [ACCBITS:0]    ACC_MAX_W = {1'b0, ACC_MAX};
  localparam int                  PW       = BITDEPTH + 10;

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  state_t               state_q;
  logic [ACCBITS-1:0]   acc_q;
  logic                 gate_q;
  logic signed [PW-1:0] prod_q, prod_d;
  logic [BITDEPTH-1:0]  audio_out_q, audio_out_d;

  logic                 rise, fall;
  logic [ACCBITS:0]     acc_w, a_step, d_step, r_step;
  logic [ACCBITS:0]     attack_sum, target_w, decay_lim;

  function automatic logic [ACCBITS:0] lin_step(input logic [7:0] rate);
    return {{(ACCBITS-7){1'b0}}, rate} + (ACCBITS+1)'(1);
  endfunction

`ifdef ENVELOPE_EXP_RELEASE_EN
  function automatic logic [ACCBITS:0] exp_step(input logic [7:0] level, input logic [7:0] rate);
    logic [17:0] p;
    p = ({10'd0, level} + 18'd1) * ({10'd0, rate} + 18'd1);
    return (ACCBITS+1)'(p >> 4) + (ACCBITS+1)'(1);
  endfunction

  assign d_step = exp_step(acc_q[ACCBITS-1 -: 8], decay_rate);
  assign r_step = exp_step(acc_q[ACCBITS-1 -: 8], release_rate);
`else
  assign d_step = lin_step(decay_rate);
  assign r_step = lin_step(release_rate);
`endif

  assign a_step     = lin_step(attack_rate);
  assign acc_w      = {1'b0, acc_q};
  assign attack_sum = acc_w + a_step;
  assign target_w   = {1'b0, sustain_level, {(ACCBITS-8){1'b0}}};
  assign decay_lim  = target_w + d_step;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  // Retrigger keeps the current level so a new note never clicks.
  always_ff @(posedge sample_clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      gate_q <= gate;
      if (rise) begin
        state_q <= ATTACK;
      end else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
        state_q <= RELEASE;
      end else begin
        case (state_q)
          IDLE: acc_q <= '0;
          ATTACK: begin
            if (attack_sum >= ACC_MAX_W) begin
              acc_q   <= ACC_MAX;
              state_q <= DECAY;
            end else begin
              acc_q <= attack_sum[ACCBITS-1:0];
            end
          end
          DECAY: begin
            if (acc_w <= decay_lim) begin
              acc_q   <= target_w[ACCBITS-1:0];
              state_q <= SUSTAIN;
            end else begin
              acc_q <= acc_q - d_step[ACCBITS-1:0];
            end
          end
          SUSTAIN: acc_q <= target_w[ACCBITS-1:0];
          RELEASE: begin
            if (acc_w <= r_step) begin
              acc_q   <= '0;
              state_q <= IDLE;
            end else begin
              acc_q <= acc_q - r_step[ACCBITS-1:0];
            end
          end
          default: begin
            acc_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign envelope = acc_q[ACCBITS-1 -: 8];
  assign active   = (state_q != IDLE);

  logic signed [BITDEPTH:0] centered;
  logic signed [PW-1:0]     cen_x, env_x, shifted;

  assign centered = $signed({1'b0, audio_in}) - $signed({1'b0, MIDPOINT});
  assign cen_x    = PW'(centered);
  assign env_x    = PW'($signed({1'b0, envelope}));
  assign prod_d   = cen_x * env_x;
  // Floor shift keeps the scaled sample inside the unsigned range.
  assign shifted     = prod_q >>> 8;
  assign audio_out_d = BITDEPTH'(shifted + $signed(PW'(MIDPOINT)));

  always_ff @(posedge sample_clock or posedge reset) begin
    if (reset) begin
      prod_q      <= '0;
      audio_out_q <= MIDPOINT;
    end else begin
      prod_q      <= prod_d;
      audio_out_q <= audio_out_d;
    end
  end

  assign audio_out = audio_out_q;

endmodule

// File: tb/tb_envelope_vca.sv
// Directed + randomized bench for envelope_vca against a cycle-level arithmetic model.
module tb_envelope_vca;

  localparam int MID  = 8191;
  localparam int AMAX = 65535;

  logic        sample_clock = 1'b0;
  logic        reset;
  logic        gate;
  logic [7:0]  attack_rate, decay_rate, sustain_level, release_rate;
  logic [13:0] audio_in;
  logic [13:0] audio_out;
  logic [7:0]  envelope;
  logic        active;

  envelope_vca dut (
    .sample_clock (sample_clock),
    .reset        (reset),
    .gate         (gate),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .sustain_level(sustain_level),
    .release_rate (release_rate),
    .audio_in     (audio_in),
    .audio_out    (audio_out),
    .envelope     (envelope),
    .active       (active)
  );

  always #5 sample_clock = ~sample_clock;

  int checks = 0;
  int errors = 0;
  bit rand_audio = 1'b1;

  // Model state: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
  int m_state, m_acc, m_s1, m_out;
  bit m_gate_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int vca(input int ain, input int env);
    int p;
    p = (ain - MID) * env;
    if (p >= 0) return MID + p / 256;
    return MID - ((-p + 255) / 256);
  endfunction

  function automatic int fall_step(input int acc, input int rate);
`ifdef ENVELOPE_EXP_RELEASE_EN
    return ((((acc / 256) + 1) * (rate + 1)) / 16) + 1;
`else
    return rate + 1;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_acc = 0; m_gate_d = 0; m_s1 = MID; m_out = MID;
  endtask

  task automatic model_edge();
    bit rise, fall;
    int st, target;
    rise = gate && !m_gate_d;
    fall = !gate && m_gate_d;
    m_out = m_s1;
    m_s1 = vca(int'(audio_in), m_acc / 256);
    target = int'(sustain_level) * 256;
    if (rise) m_state = 1;
    else if (fall && m_state >= 1 && m_state <= 3) m_state = 4;
    else begin
      case (m_state)
        0: m_acc = 0;
        1: if (m_acc + attack_rate + 1 >= AMAX) begin m_acc = AMAX; m_state = 2; end
           else m_acc = m_acc + attack_rate + 1;
        2: begin
          st = fall_step(m_acc, decay_rate);
          if (m_acc <= target + st) begin m_acc = target; m_state = 3; end
          else m_acc = m_acc - st;
        end
        3: m_acc = target;
        default: begin
          st = fall_step(m_acc, release_rate);
          if (m_acc <= st) begin m_acc = 0; m_state = 0; end
          else m_acc = m_acc - st;
        end
      endcase
    end
    m_gate_d = gate;
  endtask

  task automatic tick();
    @(posedge sample_clock);
    model_edge();
    #1;
    chk("envelope", envelope, m_acc / 256);
    chk("active", active, m_state != 0);
    chk("audio_out", audio_out, m_out);
    if (rand_audio) audio_in = 14'($urandom_range(0, 16383));
  endtask

  task automatic run_until_state(input int st, input int budget);
    int n;
    n = 0;
    while (m_state != st && n < budget) begin tick(); n++; end
    chk("reach_state_budget", n < budget, 1);
  endtask

  initial begin
    reset = 1'b1; gate = 1'b0;
    attack_rate = 8'd255; decay_rate = 8'd255; sustain_level = 8'h80; release_rate = 8'd255;
    audio_in = 14'($urandom_range(0, 16383));
    model_reset();
    #2;
    chk("reset_env", envelope, 0);
    chk("reset_active", active, 0);
    chk("reset_audio", audio_out, MID);
    @(negedge sample_clock); reset = 1'b0;
    repeat (4) tick();

    // Attack at full rate, then decay into sustain 0x80
    gate = 1'b1;
    repeat (257) tick();
    chk("attack_top", envelope, 8'hFF);
    repeat (129) tick();
    chk("sustain_80", envelope, 8'h80);
    sustain_level = 8'h40; tick();
    chk("sustain_track_40", envelope, 8'h40);
    sustain_level = 8'h80; tick();

    // Release from 0x8000 reaches zero on the 128th release step
    gate = 1'b0; tick();
    repeat (127) tick();
    chk("release_127_active", active, 1);
    chk("release_127_env", envelope, 1);
    tick();
    chk("release_done_active", active, 0);
    chk("release_done_env", envelope, 0);

    // Retrigger on the cycle release would hit zero
    gate = 1'b1;
    run_until_state(3, 1000);
    tick();
    gate = 1'b0; tick();
    repeat (127) tick();
    gate = 1'b1; tick();
    chk("retrig_active", active, 1);
    chk("retrig_env", envelope, 1);

    // VCA at full envelope
    sustain_level = 8'hFF;
    run_until_state(3, 1000);
    repeat (2) tick();
    rand_audio = 1'b0;
    audio_in = 14'd16383; repeat (2) tick();
    chk("vca_max", audio_out, 16351);
    audio_in = 14'd0; repeat (2) tick();
    chk("vca_min", audio_out, 31);
    rand_audio = 1'b1;

    // Release from full scale with a small rate
    gate = 1'b0; release_rate = 8'd15;
    run_until_state(0, 5000);
    gate = 1'b1; attack_rate = 8'd255;
    run_until_state(2, 1000);
    gate = 1'b0; tick();
    tick();
`ifdef ENVELOPE_EXP_RELEASE_EN
    chk("exp_first_step_env", envelope, 8'hFE);
`else
    chk("lin_first_step_env", envelope, 8'hFF);
`endif
    run_until_state(0, 5000);
    tick();
    chk("idle_after_release", envelope, 0);
    rand_audio = 1'b0; audio_in = 14'($urandom_range(0, 16383));
    repeat (2) tick();
    chk("vca_env_zero", audio_out, MID);
    rand_audio = 1'b1;

    // Randomized gates and controls
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) gate = ~gate;
      if ($urandom_range(0, 31) == 0) sustain_level = 8'($urandom);
      if ($urandom_range(0, 31) == 0) attack_rate = 8'($urandom_range(64, 255));
      if ($urandom_range(0, 31) == 0) decay_rate = 8'($urandom_range(64, 255));
      if ($urandom_range(0, 31) == 0) release_rate = 8'($urandom_range(64, 255));
      tick();
    end

    // Async reset mid-attack, no clock edge
    gate = 1'b0; tick(); gate = 1'b1; attack_rate = 8'd100;
    repeat (20) tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset_env", envelope, 0);
    chk("async_reset_active", active, 0);
    chk("async_reset_audio", audio_out, MID);
    @(negedge sample_clock); reset = 1'b0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
